// File: rtl/fifo_read_drain.sv
// fifo_read_drain: read-side consumer of the dual-clock FIFO (ClkRead domain only).
// Latency: READ_LATENCY+1 cycles from the first pop to outValid, then one byte per cycle.
// Backpressure: pops are issued only while buffer credit covers every in-flight byte,
//   so outReady=0 stalls the FIFO instead of dropping data.
// Optional: define SEQ_CHECK_EN to add the sticky seqErr output (incrementing-byte checker).
// Ports: ClkRead/reset (async, active-high); drainEn enables popping;
//   fifoEmpty/fifoRead/fifoData form the FIFO read port;
//   outValid/outReady/outData form the downstream stream;
//   busy flags outstanding work; popCount counts pops modulo 2^COUNT_WIDTH.
module fifo_read_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   ClkRead,
    input  logic                   reset,
    input  logic                   drainEn,
    input  logic                   fifoEmpty,
    output logic                   fifoRead,
    input  logic [DATA_WIDTH-1:0]  fifoData,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [DATA_WIDTH-1:0]  outData,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] popCount
`ifdef SEQ_CHECK_EN
    ,
    output logic                   seqErr
`endif
);

    localparam int DEPTH = READ_LATENCY + 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW    = $clog2(DEPTH + 1);
    // Headroom so occupancy + in-flight never wraps in the credit sum.
    localparam int SW    = OW + 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [READ_LATENCY-1:0]  r_pipe;
    logic [READ_LATENCY-1:0]  w_pipe_nxt;
    logic [DATA_WIDTH-1:0]    r_buf [DEPTH];
    logic [PW-1:0]            r_wr;
    logic [PW-1:0]            r_rd;
    logic [OW-1:0]            r_occ;
    logic [DATA_WIDTH-1:0]    r_last;
    logic [COUNT_WIDTH-1:0]   r_pop_cnt;
    logic [SW-1:0]            w_inflight;
    logic [SW-1:0]            w_credit;
    logic                     w_cap;
    logic                     w_deq;

    // The oldest pop reaches the top of the pipe exactly when its data is on fifoData.
    assign w_cap = r_pipe[READ_LATENCY-1];
    assign w_deq = outValid && outReady;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + SW'(r_pipe[i]);
        end
    end

    always_comb begin
        w_pipe_nxt    = '0;
        w_pipe_nxt[0] = fifoRead;
        for (int i = 1; i < READ_LATENCY; i++) begin
            w_pipe_nxt[i] = r_pipe[i-1];
        end
    end

    // A slot freed by this cycle's dequeue may be reused by this cycle's pop,
    // which keeps the stream bubble-free with a buffer of only DEPTH entries.
    assign w_credit = SW'(r_occ) + w_inflight - SW'(w_deq);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge ClkRead or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (drainEn) w_state_nxt = S_RUN;
            S_RUN:  if (!drainEn) w_state_nxt = S_STOP;
            S_STOP: if (w_inflight == '0) w_state_nxt = drainEn ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        fifoRead = (r_state == S_RUN) && !fifoEmpty && (w_credit < SW'(DEPTH));
        busy     = (w_inflight != '0) || (r_occ != '0) || (r_state == S_STOP);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge ClkRead or posedge reset) begin
        if (reset) begin
            r_pipe    <= '0;
            r_wr      <= '0;
            r_rd      <= '0;
            r_occ     <= '0;
            r_last    <= '0;
            r_pop_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_pipe <= w_pipe_nxt;
            if (fifoRead) begin
                r_pop_cnt <= r_pop_cnt + COUNT_WIDTH'(1);
            end
            if (w_cap) begin
                r_buf[r_wr] <= fifoData;
                r_wr        <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
            end
            if (w_deq) begin
                r_last <= r_buf[r_rd];
                r_rd   <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
            end
            case ({w_cap, w_deq})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign outValid = (r_occ != '0);
    // When empty, keep showing the last byte handed downstream.
    assign outData  = outValid ? r_buf[r_rd] : r_last;
    assign popCount = r_pop_cnt;

`ifdef SEQ_CHECK_EN
    logic                  r_seeded;
    logic [DATA_WIDTH-1:0] r_expect;
    logic                  r_seq_err;

    // r_expect holds the previous dequeued byte; the next one must be that plus one.
    always_ff @(posedge ClkRead or posedge reset) begin
        if (reset) begin
            r_seeded  <= 1'b0;
            r_expect  <= '0;
            r_seq_err <= 1'b0;
        end else if (w_deq) begin
            r_seeded <= 1'b1;
            r_expect <= outData;
            if (r_seeded && (outData != r_expect + DATA_WIDTH'(1))) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign seqErr = r_seq_err;
`endif

endmodule

// File: doc/fifo_read_drain.md
Name: fifo_read_drain

Overview:
Read-side consumer for the dual-clock FIFO, living entirely in the ClkRead domain. It issues pop strobes against the FIFO empty flag and absorbs the FIFO's fixed read latency with a small credit-managed output buffer. It presents popped bytes to downstream logic over a valid/ready stream with no bubbles under continuous readiness. It is the mirror of the write-side producer, which drives ControlIn/dataIn and honours haltInput.

Parameters:
DATA_WIDTH, 8, width of fifoData/outData
READ_LATENCY, 1, ClkRead cycles from pop strobe sampled to fifoData valid; legal 1 or 2
COUNT_WIDTH, 16, width of popCount

Ports:
ClkRead  input  1  read-domain clock, rising edge
reset  input  1  asynchronous, active-high reset
drainEn  input  1  1 = pop from FIFO while space allows; 0 = stop issuing pops
fifoEmpty  input  1  FIFO empty flag, synchronous to ClkRead
fifoRead  output  1  pop strobe to FIFO, one pop per cycle high
fifoData  input  DATA_WIDTH  FIFO read data, valid READ_LATENCY cycles after a pop
outValid  output  1  outData holds a byte
outReady  input  1  downstream accepts when outValid && outReady at rising edge
outData  output  DATA_WIDTH  head of output buffer
busy  output  1  pops in flight or buffer non-empty
popCount  output  COUNT_WIDTH  total pops issued since reset, wraps modulo 2^COUNT_WIDTH

Behaviour:
- Reset (async assert, any time): fifoRead=0, outValid=0, outData=0, busy=0, popCount=0, in-flight pipe cleared, buffer emptied, state=IDLE. Pops in flight at reset are discarded.
- Buffer: circular, DEPTH = READ_LATENCY+1 entries; occupancy counter 0..DEPTH; wr/rd pointers wrap at DEPTH.
- In-flight tracker: shift register of READ_LATENCY bits; bit 0 set when fifoRead=1; top bit set means fifoData captured into buffer at that edge.
- Credit rule: fifoRead = (state==RUN) && !fifoEmpty && (occupancy + inFlight - deqThisCycle) < DEPTH, where deqThisCycle = outValid && outReady. Combinational from registered state plus fifoEmpty/outReady; never overflows buffer.
- Simultaneous capture and dequeue: occupancy unchanged, both pointers advance.
- Dequeue on empty buffer impossible (outValid=0). outData = buffer[rdPtr] when outValid, else holds last value.
- Throughput: with fifoEmpty=0, outReady=1, one byte per cycle sustained after first-byte latency READ_LATENCY+1 cycles (fifoRead edge to outValid high).
- FSM:
  - IDLE: fifoRead=0. drainEn=1 -> RUN.
  - RUN: pops per credit rule. drainEn=0 -> STOP.
  - STOP: no new pops; wait until inFlight==0 -> IDLE (drainEn=1 at that edge -> RUN directly).
  - Buffered bytes continue to drain downstream in every state.
- busy = (inFlight!=0) || (occupancy!=0) || (state==STOP).
- popCount increments on each cycle fifoRead=1; wraps to 0.
- fifoEmpty toggling mid-burst: pops simply pause; no byte lost or duplicated.

Optional Feature:
SEQ_CHECK_EN: adds output seqErr (1 bit, sticky) and expected-byte register. First dequeued byte after reset seeds expectation; each later dequeue compares against expected+1 mod 2^DATA_WIDTH; mismatch sets seqErr until reset. Without macro: no seqErr port, no checker logic.

Test Plan:
- Reset mid-burst: reset at 3rd pop with bytes in flight -> all outputs 0 immediately, no stale byte appears after reset release.
- Streaming: FIFO preloaded 0x00..0x1D (30 bytes), drainEn=1, outReady=1 -> outData 0x00..0x1D in order, one per cycle, popCount=30, busy falls after last dequeue.
- Backpressure: outReady=0 for 10 cycles with FIFO full -> exactly DEPTH pops issued then fifoRead=0; on outReady=1 bytes resume in order, none lost.
- Empty gaps: fifoEmpty toggles every 3 cycles -> fifoRead never high while fifoEmpty=1; output order preserved.
- Drain stop: drainEn dropped while READ_LATENCY=2 pops in flight -> both bytes delivered, state returns IDLE, no further pops.
- SEQ_CHECK_EN: stream 0x00,0x01,0x03 -> seqErr=1 after third dequeue, remains 1 until reset.
